// File: rtl/ncmem_pkg.sv
// Shared types and constants for the non-cacheable memory NoC arbiter.
package ncmem_pkg;
   localparam int NOC_DATA_WIDTH = 64;
   localparam int NOC_LEN_LSB    = 22;
   localparam int NOC_LEN_WIDTH  = 8;

   typedef enum logic {R_IDLE, R_BODY} req_state_e;
   typedef enum logic {P_IDLE, P_BODY} resp_state_e;
endpackage

// File: rtl/ncmem_noc_arb_if.sv
// NoC2 request / NoC3 response bundle between requesters, arbiter and bridge.
interface ncmem_noc_arb_if #(
   parameter int NUM_CH      = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int ORDER_DEPTH = 8
);
   localparam int OW = $clog2(ORDER_DEPTH) + 1;

   logic [NUM_CH-1:0]            req_in_val;
   logic [NUM_CH*DATA_WIDTH-1:0] req_in_data;
   logic [NUM_CH-1:0]            req_in_rdy;
   logic                         req_out_val;
   logic [DATA_WIDTH-1:0]        req_out_data;
   logic                         req_out_rdy;
   logic                         resp_in_val;
   logic [DATA_WIDTH-1:0]        resp_in_data;
   logic                         resp_in_rdy;
   logic [NUM_CH-1:0]            resp_out_val;
   logic [NUM_CH*DATA_WIDTH-1:0] resp_out_data;
   logic [NUM_CH-1:0]            resp_out_rdy;
   logic [OW-1:0]                outstanding;

   modport master (
      output req_in_val, req_in_data, req_out_rdy, resp_in_val, resp_in_data, resp_out_rdy,
      input  req_in_rdy, req_out_val, req_out_data, resp_in_rdy, resp_out_val, resp_out_data,
             outstanding
   );
   modport slave (
      input  req_in_val, req_in_data, req_out_rdy, resp_in_val, resp_in_data, resp_out_rdy,
      output req_in_rdy, req_out_val, req_out_data, resp_in_rdy, resp_out_val, resp_out_data,
             outstanding
   );
endinterface

// File: rtl/ncmem_order_fifo.sv
// Grant-order FIFO: records which channel each forwarded request came from.
module ncmem_order_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic         do_push, do_pop;

   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      wr_d    = wr_q + {{AW{1'b0}}, do_push};
      rd_d    = rd_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty = (wr_q == rd_q);
   assign count = wr_q - rd_q;
   assign dout  = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/ncmem_noc_arb.sv
// Packet-level N:1 request arbiter and in-order 1:N response router feeding one AXI bridge.
module ncmem_noc_arb
   import ncmem_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DATA_WIDTH  = NOC_DATA_WIDTH,
   parameter int LEN_LSB     = NOC_LEN_LSB,
   parameter int LEN_WIDTH   = NOC_LEN_WIDTH,
   parameter int ORDER_DEPTH = 8
) (
   input logic             clk,
   input logic             rst,
   ncmem_noc_arb_if.slave  bus
);
   localparam int CW = $clog2(NUM_CH);

   req_state_e            rs_q, rs_d;
   resp_state_e           ps_q, ps_d;
   logic [CW-1:0]         grant_q, grant_d, rr_q, rr_d, sel, cur, head;
   logic [CW:0]           cand;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d, prem_q, prem_d, hlen, plen;
   logic                  sel_vld, act, pact, out_val, req_hs, resp_hs;
   logic                  push, pop, full, empty, p_rdy;
   logic [NUM_CH-1:0]     in_rdy, p_val;
   logic [DATA_WIDTH-1:0] req_flit [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign req_flit[i] = bus.req_in_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign bus.resp_out_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.resp_in_data;
   end

   // Round-robin: scan downward so the candidate nearest rr_q is the last one written.
   always_comb begin
      sel     = rr_q;
      sel_vld = 1'b0;
      cand    = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         cand = {1'b0, rr_q} + (CW+1)'(k);
         if (cand >= (CW+1)'(NUM_CH)) cand = cand - (CW+1)'(NUM_CH);
         if (bus.req_in_val[cand[CW-1:0]]) begin
            sel     = cand[CW-1:0];
            sel_vld = 1'b1;
         end
      end
   end

   // Outputs are gated by rst so every val/rdy reads 0 while reset is held.
   always_comb begin
      rs_d    = rs_q;
      grant_d = grant_q;
      rem_d   = rem_q;
      rr_d    = rr_q;
      push    = 1'b0;
      cur     = (rs_q == R_BODY) ? grant_q : sel;
      act     = !rst && ((rs_q == R_BODY) || (sel_vld && !full));
      out_val = act && bus.req_in_val[cur];
      in_rdy  = '0;
      in_rdy[cur] = act && bus.req_out_rdy;
      req_hs  = out_val && bus.req_out_rdy;
      hlen    = req_flit[cur][LEN_LSB +: LEN_WIDTH];
      case (rs_q)
         R_IDLE: if (req_hs) begin
            push    = 1'b1;
            grant_d = cur;
            rem_d   = hlen;
            rr_d    = (cur == CW'(NUM_CH - 1)) ? '0 : cur + CW'(1);
            if (hlen != '0) rs_d = R_BODY;
         end
         R_BODY: if (req_hs) begin
            rem_d = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) rs_d = R_IDLE;
         end
         default: rs_d = R_IDLE;
      endcase
   end

   always_comb begin
      ps_d   = ps_q;
      prem_d = prem_q;
      pop    = 1'b0;
      pact   = !rst && !empty;
      p_val  = '0;
      p_val[head] = pact && bus.resp_in_val;
      p_rdy  = pact && bus.resp_out_rdy[head];
      resp_hs = bus.resp_in_val && p_rdy;
      plen   = bus.resp_in_data[LEN_LSB +: LEN_WIDTH];
      case (ps_q)
         P_IDLE: if (resp_hs) begin
            prem_d = plen;
            if (plen == '0) pop = 1'b1;
            else            ps_d = P_BODY;
         end
         P_BODY: if (resp_hs) begin
            prem_d = prem_q - LEN_WIDTH'(1);
            if (prem_q == LEN_WIDTH'(1)) begin
               pop  = 1'b1;
               ps_d = P_IDLE;
            end
         end
         default: ps_d = P_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_q    <= R_IDLE;
         ps_q    <= P_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         rem_q   <= '0;
         prem_q  <= '0;
      end else begin
         rs_q    <= rs_d;
         ps_q    <= ps_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         rem_q   <= rem_d;
         prem_q  <= prem_d;
      end
   end

   ncmem_order_fifo #(.DEPTH(ORDER_DEPTH), .W(CW)) u_order (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .din(cur),
      .dout(head), .full(full), .empty(empty), .count(bus.outstanding)
   );

   assign bus.req_out_val  = out_val;
   assign bus.req_out_data = req_flit[cur];
   assign bus.req_in_rdy   = in_rdy;
   assign bus.resp_out_val = p_val;
   assign bus.resp_in_rdy  = p_rdy;
endmodule
